uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin packet arbiter that shares the single UART transmit path between NREQ independent requesters.
- Sits between the client logic and the Tx FIFO write port: drives write_uart / write_data and obeys the Tx FIFO full flag.
- Grants one requester for a whole packet (until req_last or the length cap), optionally prefixing a source-ID header byte.

Parameters:
- DBITS, 8, data bits per word; must match the UART core.
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; ID_W = $clog2(NREQ).
- MAX_PKT, 16, maximum payload bytes per grant before forced release.
- HDR_MARK, 6'b101010, upper DBITS-ID_W bits of the header byte.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*DBITS  per-requester byte; requester i occupies bits [i*DBITS +: DBITS].
- req_last  in  NREQ  marks the final byte of the requester's packet.
- req_ready  out  NREQ  byte accepted this cycle when valid & ready.
- tx_full  in  1  Tx FIFO full flag.
- write_uart  out  1  Tx FIFO write strobe, one byte per high cycle.
- write_data  out  DBITS  byte to the Tx FIFO.
- grant_id  out  ID_W  currently granted requester.
- busy  out  1  high in any state other than IDLE.
- pkt_trunc  out  1  one-cycle pulse when a packet is cut at MAX_PKT.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = IDLE, rr_ptr = NREQ-1, grant_id = 0, byte_cnt = 0, pkt_trunc = 0.
  - Combinational outputs evaluate to 0: write_uart, req_ready, busy. write_data = 0.
  - Reset asserted mid-packet aborts the packet immediately; no further strobes are issued. The partially written packet stays in the FIFO.
- State register states: IDLE, HEADER, PAYLOAD.
- IDLE:
  - If any req_valid is high, grant the first valid requester searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register grant_id, clear byte_cnt, then go to HEADER (macro defined) or PAYLOAD.
  - No writes occur in IDLE, so there is always at least one idle cycle between packets.
- HEADER:
  - write_uart = ~tx_full; write_data = {HDR_MARK, grant_id}.
  - On a write, go to PAYLOAD. Stay in HEADER while tx_full is high.
- PAYLOAD:
  - req_ready[grant_id] = ~tx_full; all other ready bits are 0.
  - write_uart = req_valid[grant_id] & ~tx_full; write_data = granted req_data.
  - On each write, byte_cnt increments.
  - If the written byte has req_last: rr_ptr <= grant_id, go to IDLE.
  - Else if byte_cnt reaches MAX_PKT-1 on this write: pulse pkt_trunc, rr_ptr <= grant_id, go to IDLE. The requester's remaining bytes form a later packet.
  - A valid gap on the granted requester holds the grant; the arbiter does not time out.
- Timing:
  - write_uart, write_data and req_ready are combinational from registered state and grant plus live tx_full / req_valid. Zero latency from valid to strobe.
  - No write is ever issued while tx_full is high.
- Field widths:
  - byte_cnt width is $clog2(MAX_PKT+1).
  - grant_id and rr_ptr wrap modulo NREQ; NREQ need not be a power of two, and IDs >= NREQ are never granted.
- Simultaneous events:
  - Requests arriving during PAYLOAD wait.
  - The granted requester's req_valid falling in IDLE before the grant registers is harmless, because arbitration samples only in IDLE.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - The HEADER state exists; each packet is preceded by the byte {HDR_MARK, grant_id}.
  - The header does not count toward MAX_PKT.
- Undefined:
  - HEADER is removed and IDLE goes directly to PAYLOAD.
  - The byte stream contains payload only, and packets are separated only by time.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, HEADER, PAYLOAD);
  - the default HDR_MARK;
  - a function next_rr(ptr, valid_vec) returning the next granted index.
- One sub-module, rr_pick: a combinational round-robin priority selector taking req_valid and rr_ptr and returning the grant index plus an any-valid flag. It is reused by other arbiters in the codebase.
- The FSM, counter and output muxing stay in the top module.

Test Plan:
- Header enabled, req 2 sends 0x11, 0x22 (last), tx_full = 0:
  - expect write strobes 0xAA, 0x11, 0x22 on consecutive cycles;
  - expect req_ready[2] high only in PAYLOAD, then busy low.
- All 4 requesters hold a 1-byte packet continuously: expect grant order 0, 1, 2, 3, 0, with exactly one IDLE cycle between packets.
- tx_full is held high for 5 cycles mid-payload:
  - expect no write_uart and req_ready = 0 during those cycles;
  - when full drops, the stalled byte is written exactly once, with no duplicate and no loss.
- Req 1 streams 20 bytes with no last, MAX_PKT = 16:
  - expect pkt_trunc after the 16th byte and a return to IDLE;
  - req 1 is regranted for the remaining 4 bytes only after other pending requesters are served.
- Reset is pulsed low mid-PAYLOAD on a 5-byte packet at byte 3:
  - expect write_uart = 0 immediately and busy = 0;
  - after release, the arbiter starts with requester 0 priority (rr_ptr = 3).
- Macro undefined, req 0 sends 0x5A (last): expect a single strobe 0x5A with no header byte.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiters.
// Holds the state encoding, the default header mark and the round-robin search.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [5:0] HDR_MARK_DEFAULT = 6'b101010;
    localparam int         RR_MAX           = 8;

    // First valid index after ptr, wrapping modulo nreq; returns ptr when none is valid.
    function automatic logic [2:0] next_rr(
        input logic [2:0]        ptr,
        input logic [RR_MAX-1:0] valid_vec,
        input int                nreq
    );
        logic       found;
        logic [2:0] idx;
        next_rr = ptr;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if (k <= nreq && !found && valid_vec[idx]) begin
                next_rr = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Searches from rr_ptr+1 upward, wrapping at NREQ, so the last winner has lowest priority.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] grant,
    output logic            any_valid
);

    logic [RR_MAX-1:0] valid_ext;

    assign valid_ext = RR_MAX'(req_valid);
    assign grant     = ID_W'(next_rr(3'(rr_ptr), valid_ext, NREQ));
    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART Tx FIFO write port.
// Define UART_ARB_HDR_EN to prefix each packet with a {HDR_MARK, grant_id} byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int NREQ    = 4,
    parameter int ID_W    = $clog2(NREQ),
    parameter int MAX_PKT = 16
`ifdef UART_ARB_HDR_EN
    ,
    parameter logic [DBITS-ID_W-1:0] HDR_MARK = HDR_MARK_DEFAULT
`endif
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DBITS-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  tx_full,
    output logic                  write_uart,
    output logic [DBITS-1:0]      write_data,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  pkt_trunc
);

    localparam int CNT_W = $clog2(MAX_PKT + 1);

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   grant_id_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic              pkt_trunc_reg;

    logic [ID_W-1:0]   pick_id;
    logic              any_valid;
    logic              granted_valid;
    logic              granted_last;
    logic [DBITS-1:0]  granted_data;
    logic              in_payload;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (pick_id),
        .any_valid (any_valid)
    );

    assign granted_valid = req_valid[grant_id_reg];
    assign granted_last  = req_last[grant_id_reg];
    assign granted_data  = req_data[grant_id_reg*DBITS +: DBITS];
    assign in_payload    = (state_reg == PAYLOAD);

    // Only the granted lane sees ready, and only while the FIFO can take a byte.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = in_payload && (grant_id_reg == ID_W'(gi)) && !tx_full;
        end
    endgenerate

    always_comb begin
        write_uart = 1'b0;
        write_data = '0;
        case (state_reg)
`ifdef UART_ARB_HDR_EN
            HEADER: begin
                write_uart = !tx_full;
                write_data = {HDR_MARK, grant_id_reg};
            end
`endif
            PAYLOAD: begin
                write_uart = granted_valid && !tx_full;
                write_data = granted_data;
            end
            default: begin
                write_uart = 1'b0;
                write_data = '0;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign grant_id  = grant_id_reg;
    assign pkt_trunc = pkt_trunc_reg;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= ID_W'(NREQ - 1);
            grant_id_reg  <= '0;
            byte_cnt_reg  <= '0;
            pkt_trunc_reg <= 1'b0;
        end else begin
            pkt_trunc_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        grant_id_reg <= pick_id;
                        byte_cnt_reg <= '0;
`ifdef UART_ARB_HDR_EN
                        state_reg    <= HEADER;
`else
                        state_reg    <= PAYLOAD;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                HEADER: begin
                    if (!tx_full) begin
                        state_reg <= PAYLOAD;
                    end
                end
`endif
                PAYLOAD: begin
                    if (write_uart) begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (granted_last) begin
                            rr_ptr_reg <= grant_id_reg;
                            state_reg  <= IDLE;
                        end else if (byte_cnt_reg == CNT_W'(MAX_PKT - 1)) begin
                            // Leftover bytes of this requester become a new packet later.
                            pkt_trunc_reg <= 1'b1;
                            rr_ptr_reg    <= grant_id_reg;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; expects header bytes when UART_ARB_HDR_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
`ifdef UART_ARB_HDR_EN
    localparam int HDRN = 1;
`else
    localparam int HDRN = 0;
`endif
    localparam logic [5:0] MARK = 6'b101010;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_full;
    logic        write_uart;
    logic [7:0]  write_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        pkt_trunc;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_tx_arbiter dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_full    (tx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .pkt_trunc  (pkt_trunc)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       hdr;
        logic       trunc;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[4][$];
    logic [3:0] hold = 4'b0;
    int         checks = 0;
    int         errors = 0;
    int         write_cnt = 0;
    int         idle_run = 0;
    bit         gap_chk = 1'b0;
    bit         stall_chk = 1'b0;
    bit         trunc_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src_push(input int id, input logic [7:0] data, input logic last);
        src_q[id].push_back({last, data});
    endtask

    task automatic exp_byte(input int id, input logic [7:0] data, input logic trunc);
        exp_q.push_back({2'(id), data, 1'b0, trunc});
    endtask

    task automatic exp_hdr(input int id);
        if (HDRN == 1) exp_q.push_back({2'(id), {MARK, 2'(id)}, 1'b1, 1'b0});
    endtask

    // One clock: drive lanes, sample #1 later, score writes, retire accepted bytes.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0 && !hold[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        chk("pkt_trunc", 32'(pkt_trunc), 32'(trunc_pend));
        trunc_pend = 1'b0;
        if (pkt_trunc) chk("trunc_to_idle", 32'(busy), 0);
        if (stall_chk) begin
            chk("stall_write", 32'(write_uart), 0);
            chk("stall_ready", 32'(req_ready), 0);
        end
        if (!busy) begin
            chk("idle_write", 32'(write_uart), 0);
            chk("idle_ready", 32'(req_ready), 0);
            idle_run++;
        end else begin
            if (gap_chk && idle_run != 0) chk("idle_gap", 32'(idle_run), 1);
            idle_run = 0;
        end
        if (write_uart) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(write_uart), 0);
            end else begin
                e = exp_q.pop_front();
                $display("tx byte %02h grant %0d hdr %0d", write_data, grant_id, e.hdr);
                chk("write_data", 32'(write_data), 32'(e.data));
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("req_ready", 32'(req_ready), e.hdr ? 0 : (1 << e.id));
                trunc_pend = e.trunc;
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < max) begin
            cycle();
            n++;
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic wait_writes(input string tag, input int target, input int max);
        int n = 0;
        while (write_cnt < target && n < max) begin
            cycle();
            n++;
        end
        chk(tag, 32'(write_cnt >= target), 1);
    endtask

    task automatic wait_busy(input string tag, input int max);
        int n = 0;
        while (busy !== 1'b1 && n < max) begin
            cycle();
            n++;
        end
        chk(tag, 32'(busy), 1);
    endtask

    initial begin
        int base;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_100MHz);
        #1;
        chk("rst_write", 32'(write_uart), 0);
        chk("rst_data", 32'(write_data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_trunc", 32'(pkt_trunc), 0);
        reset = 1'b1;
        @(negedge clk_100MHz);

        // All four hold 1-byte packets: order 0,1,2,3,0 with one idle cycle between
        src_push(0, 8'h30, 1'b1); src_push(0, 8'h40, 1'b1);
        src_push(1, 8'h31, 1'b1); src_push(2, 8'h32, 1'b1); src_push(3, 8'h33, 1'b1);
        exp_hdr(0); exp_byte(0, 8'h30, 1'b0);
        exp_hdr(1); exp_byte(1, 8'h31, 1'b0);
        exp_hdr(2); exp_byte(2, 8'h32, 1'b0);
        exp_hdr(3); exp_byte(3, 8'h33, 1'b0);
        exp_hdr(0); exp_byte(0, 8'h40, 1'b0);
        wait_busy("rr_start", 10);
        gap_chk = 1'b1;
        drain("rr", 100);
        gap_chk = 1'b0;

        // Req 2 sends 0x11, 0x22(last)
        src_push(2, 8'h11, 1'b0); src_push(2, 8'h22, 1'b1);
        exp_hdr(2); exp_byte(2, 8'h11, 1'b0); exp_byte(2, 8'h22, 1'b0);
        drain("pkt2", 20);

        // tx_full held 5 cycles mid-payload
        base = write_cnt;
        for (int i = 0; i < 4; i++) src_push(3, 8'h50 + 8'(i), i == 3);
        exp_hdr(3);
        for (int i = 0; i < 4; i++) exp_byte(3, 8'h50 + 8'(i), 1'b0);
        wait_writes("stall_pre", base + HDRN + 2, 20);
        tx_full   = 1'b1;
        stall_chk = 1'b1;
        repeat (5) cycle();
        tx_full   = 1'b0;
        stall_chk = 1'b0;
        drain("stall", 20);
        chk("stall_src_left", 32'(src_q[3].size()), 0);

        // Req 1 streams 20 bytes: cut after 16, others served before the remaining 4
        for (int i = 0; i < 20; i++) src_push(1, 8'h60 + 8'(i), i == 19);
        src_push(0, 8'hC0, 1'b1);
        src_push(2, 8'hC2, 1'b1);
        hold = 4'b0101;
        exp_hdr(1);
        for (int i = 0; i < 16; i++) exp_byte(1, 8'h60 + 8'(i), i == 15);
        exp_hdr(2); exp_byte(2, 8'hC2, 1'b0);
        exp_hdr(0); exp_byte(0, 8'hC0, 1'b0);
        exp_hdr(1);
        for (int i = 16; i < 20; i++) exp_byte(1, 8'h60 + 8'(i), 1'b0);
        wait_busy("trunc_start", 10);
        hold = 4'b0000;
        drain("trunc", 200);

        // Reset pulsed at payload byte 3 of a 5-byte packet
        base = write_cnt;
        for (int i = 0; i < 5; i++) src_push(2, 8'h70 + 8'(i), i == 4);
        exp_hdr(2);
        for (int i = 0; i < 5; i++) exp_byte(2, 8'h70 + 8'(i), 1'b0);
        wait_writes("abort_pre", base + HDRN + 2, 20);
        reset = 1'b0;
        #1;
        chk("abort_write", 32'(write_uart), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(req_ready), 0);
        exp_q.delete();
        src_q[2].delete();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b1;
        src_push(0, 8'h80, 1'b1); src_push(3, 8'h83, 1'b1);
        exp_hdr(0); exp_byte(0, 8'h80, 1'b0);
        exp_hdr(3); exp_byte(3, 8'h83, 1'b0);
        drain("post_rst", 30);

        // Single byte from req 0
        base = write_cnt;
        src_push(0, 8'h5A, 1'b1);
        exp_hdr(0); exp_byte(0, 8'h5A, 1'b0);
        drain("single", 20);
        chk("single_strobes", 32'(write_cnt - base), 32'(HDRN + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
